// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register ahead of the shifter.
// Back-to-back frames run with no idle gap when a byte is already held.
module uart_tx #(
    parameter int DIVISOR = 2604
) (
    input  logic       i_clock,
    input  logic       i_rst,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_start,
    output logic       o_tx_ready,
    output logic       o_tx_busy,
    output logic       o_tx_done,
    output logic       o_tx_serial
);

    localparam int CW = $clog2(DIVISOR);
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    hold_data;
    logic          hold_valid;
    logic          bit_end;
    logic          accept;

    assign bit_end    = (cnt == LAST);
    assign accept     = i_tx_start && !hold_valid;
    assign o_tx_ready = !hold_valid;
    assign o_tx_busy  = (state != IDLE);

    always_ff @(posedge i_clock or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            hold_data   <= '0;
            hold_valid  <= 1'b0;
            o_tx_serial <= 1'b1;
            o_tx_done   <= 1'b0;
        end else begin
            o_tx_done <= 1'b0;
            // accept and load are mutually exclusive: one needs hold_valid low, the other high
            if (accept) begin
                hold_data  <= i_tx_data;
                hold_valid <= 1'b1;
            end
            case (state)
                IDLE: begin
                    cnt         <= '0;
                    o_tx_serial <= 1'b1;
                    if (hold_valid) begin
                        state       <= START;
                        shreg       <= hold_data;
                        hold_valid  <= 1'b0;
                        o_tx_serial <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt         <= '0;
                        bit_idx     <= '0;
                        o_tx_serial <= shreg[0];
                        state       <= DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state       <= STOP;
                            o_tx_serial <= 1'b1;
                        end else begin
                            bit_idx     <= bit_idx + 3'd1;
                            shreg       <= {1'b0, shreg[7:1]};
                            o_tx_serial <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt       <= '0;
                        o_tx_done <= 1'b1;
                        if (hold_valid) begin
                            state       <= START;
                            shreg       <= hold_data;
                            hold_valid  <= 1'b0;
                            o_tx_serial <= 1'b0;
                        end else begin
                            state       <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx against a frame-position reference model.
// The model tracks the line as bit index pos/DIV into a 10-bit frame image.
module tb_uart_tx;

    localparam int DIV = 4;
    localparam int FRAME = 10 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_serial;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    bit         m_active;
    int         m_pos;
    logic [9:0] m_bits;
    bit         m_hold_v;
    logic [7:0] m_hold_d;
    bit         m_done;
    bit         m_acc;
    int         m_frames;
    int         dut_dones;
    int         cyc;
    int         start_cyc;
    int         done_cyc;

    uart_tx #(.DIVISOR(DIV)) dut (
        .i_clock     (clk),
        .i_rst       (rst),
        .i_tx_data   (tx_data),
        .i_tx_start  (tx_start),
        .o_tx_ready  (tx_ready),
        .o_tx_busy   (tx_busy),
        .o_tx_done   (tx_done),
        .o_tx_serial (tx_serial)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_pos    = 0;
        m_hold_v = 0;
        m_done   = 0;
    endtask

    task automatic model_step(input logic st, input logic [7:0] d);
        m_acc  = st && !m_hold_v;
        m_done = 0;
        if (m_active) begin
            m_pos++;
            if (m_pos == FRAME) begin
                m_active = 0;
                m_done   = 1;
                m_frames++;
            end
        end
        if (!m_active && m_hold_v) begin
            m_active = 1;
            m_pos    = 0;
            m_bits   = {1'b1, m_hold_d, 1'b0};
            m_hold_v = 0;
            start_cyc = cyc;
        end
        if (m_acc) begin
            m_hold_v = 1;
            m_hold_d = d;
        end
    endtask

    function automatic logic exp_serial();
        if (m_active) return m_bits[m_pos / DIV];
        return 1'b1;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".serial"}, 32'(tx_serial), 32'(exp_serial()));
        check({tag, ".ready"}, 32'(tx_ready), 32'(!m_hold_v));
        check({tag, ".busy"}, 32'(tx_busy), 32'(m_active));
        check({tag, ".done"}, 32'(tx_done), 32'(m_done));
    endtask

    // drive inputs, advance one edge, compare on the falling edge
    task automatic cycle(input string tag, input logic st, input logic [7:0] d);
        tx_start = st;
        tx_data  = d;
        @(posedge clk);
        cyc++;
        model_step(st, d);
        @(negedge clk);
        if (tx_done) begin
            dut_dones++;
            done_cyc = cyc;
        end
        check_outputs(tag);
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 1'b0, 8'($urandom));
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check({tag, ".serial"}, 32'(tx_serial), 32'd1);
        check({tag, ".ready"}, 32'(tx_ready), 32'd1);
        check({tag, ".busy"}, 32'(tx_busy), 32'd0);
        check({tag, ".done"}, 32'(tx_done), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        m_frames  = 0;
        dut_dones = 0;
        cyc       = 0;
        start_cyc = 0;
        done_cyc  = 0;

        #1 rst = 1'b1;
        #1;
        check("rst.serial", 32'(tx_serial), 32'd1);
        check("rst.ready", 32'(tx_ready), 32'd1);
        check("rst.busy", 32'(tx_busy), 32'd0);
        check("rst.done", 32'(tx_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // single frame 0xA5, accepted on the first edge after reset
        cycle("a5", 1'b1, 8'hA5);
        check("a5.accept", 32'(m_hold_v), 32'd1);
        cycle("a5", 1'b0, 8'h00);
        check("a5.lowfirst", 32'(tx_serial), 32'd0);
        idle_cycles("a5", FRAME + 6);
        check("a5.donelat", 32'(done_cyc - start_cyc), 32'(FRAME));
        check("a5.dones", 32'(dut_dones), 32'(m_frames));

        // 0x7D then 0x00 as soon as the holding register frees
        cycle("b2b", 1'b1, 8'h7D);
        while (m_hold_v || !m_active) cycle("b2b", 1'b0, 8'h00);
        cycle("b2b", 1'b1, 8'h00);
        check("b2b.accept", 32'(m_hold_v), 32'd1);
        idle_cycles("b2b", 2 * FRAME + 6);
        check("b2b.dones", 32'(dut_dones), 32'(m_frames));

        // 0xFF pulsed while full must be dropped
        cycle("full", 1'b1, 8'h11);
        cycle("full", 1'b0, 8'h00);
        cycle("full", 1'b1, 8'h22);
        cycle("full", 1'b1, 8'hFF);
        check("full.ready", 32'(tx_ready), 32'd0);
        idle_cycles("full", 2 * FRAME + 6);
        check("full.dones", 32'(dut_dones), 32'(m_frames));

        // reset during data bit 3 of 0x55, then send 0x0F
        cycle("mid", 1'b1, 8'h55);
        while (!(m_active && m_pos == 4 * DIV + 1)) cycle("mid", 1'b0, 8'h00);
        async_reset("midrst");
        idle_cycles("midrst", 3);
        check("mid.dones", 32'(dut_dones), 32'(m_frames));
        cycle("0f", 1'b1, 8'h0F);
        idle_cycles("0f", FRAME + 6);
        check("0f.dones", 32'(dut_dones), 32'(m_frames));

        // start held high with changing data
        for (int i = 0; i < 4 * FRAME; i++) cycle("hold", 1'b1, 8'($urandom));
        idle_cycles("hold", 2 * FRAME + 6);
        check("hold.dones", 32'(dut_dones), 32'(m_frames));

        // random traffic
        for (int i = 0; i < 1500; i++)
            cycle("rnd", 1'($urandom_range(0, 9) == 0), 8'($urandom));
        idle_cycles("rnd", 2 * FRAME + 6);
        check("rnd.dones", 32'(dut_dones), 32'(m_frames));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DIVISOR, default 2604, clock cycles per serial bit; legal range >= 2.
REQ-002 i_clock  input  1  system clock; all state changes on rising edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-high.
REQ-004 i_tx_data  input  8  byte to transmit; sampled only on an accepted request.
REQ-005 i_tx_start  input  1  request strobe; a request is accepted on an edge where i_tx_start=1 and o_tx_ready=1.
REQ-006 o_tx_ready  output  1  holding register empty; a new byte can be accepted.
REQ-007 o_tx_busy  output  1  frame in progress on the line (state != IDLE).
REQ-008 o_tx_done  output  1  one-cycle pulse marking the end of a frame's stop bit.
REQ-009 o_tx_serial  output  1  serial line, registered, idle high.

Function
REQ-010 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); no parity.
REQ-011 Every bit, including start and stop, SHALL be held on o_tx_serial for exactly DIVISOR cycles; frame length is 10*DIVISOR cycles.
REQ-012 Bit-timing counter SHALL be ceil(log2(DIVISOR)) bits wide, count 0..DIVISOR-1, and wrap to 0 at each bit boundary.
REQ-013 Datapath SHALL have a one-entry holding register (hold_data, hold_valid) in front of a 8-bit shift register; o_tx_ready = !hold_valid.
REQ-014 An accepted request SHALL capture i_tx_data into hold_data and set hold_valid at the same edge.
REQ-015 i_tx_start while o_tx_ready=0 SHALL be ignored; no data corruption, no queuing.
REQ-016 FSM states: IDLE, START, DATA, STOP.
REQ-017 IDLE -> START on the edge where hold_valid=1: shift register loaded from hold_data, hold_valid cleared, o_tx_serial driven 0 from that edge.
REQ-018 Latency: a request accepted at edge N from IDLE SHALL drive o_tx_serial low after edge N+1.
REQ-019 START -> DATA after DIVISOR cycles; DATA SHALL shift out bits 0..7, using a 3-bit bit index, then go to STOP after the 8th bit's DIVISOR cycles.
REQ-020 STOP SHALL drive o_tx_serial=1 for DIVISOR cycles; at its last edge, o_tx_done pulses high for exactly one cycle.
REQ-021 At the STOP-end edge, if hold_valid=1, the FSM SHALL go directly to START and load as in REQ-017, with no idle gap between frames; otherwise it goes to IDLE.
REQ-022 Holding register SHALL accept a new byte at any time it is empty, including during START/DATA/STOP.
REQ-023 On an edge that loads the shifter from the holding register, o_tx_ready was 0, so a simultaneous i_tx_start SHALL NOT be accepted; o_tx_ready rises the following cycle.
REQ-024 i_tx_data changes after acceptance SHALL NOT affect the byte being sent.
REQ-025 In IDLE, o_tx_serial SHALL be 1 and o_tx_busy 0.

Reset
REQ-026 While i_rst=1, with no wait for a clock edge: o_tx_serial=1, o_tx_ready=1, o_tx_busy=0, o_tx_done=0, state IDLE, counters 0, hold_valid=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately with the line high; the frame byte and any held byte are discarded and no o_tx_done pulse is generated.
REQ-028 After reset deassertion, the block SHALL accept a request on the first clock edge.

Verification (DIVISOR=4 unless stated)
REQ-029 From idle, send 0xA5 -> o_tx_serial = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; o_tx_done pulses once at cycle 40 after the start bit begins.
REQ-030 Send 0x7D, then 0x00 as soon as o_tx_ready rises -> two contiguous frames, 80 cycles total, stop bit directly followed by start bit, two o_tx_done pulses 40 cycles apart.
REQ-031 Pulse i_tx_start with 0xFF while the holding register is full -> request ignored; only the two previously accepted bytes appear on the line.
REQ-032 Assert i_rst during data bit 3 of 0x55 -> o_tx_serial=1 within the same cycle, o_tx_busy=0, no o_tx_done; a new byte 0x0F then sends correctly.
REQ-033 DIVISOR=2604: loop o_tx_serial into uart_rx and send 125 -> uart_rx o_rx_data=125 with one o_rx_done pulse.
REQ-034 Hold i_tx_start=1 continuously with a changing i_tx_data -> exactly one byte accepted per o_tx_ready window, and each transmitted byte equals the i_tx_data value at its accept edge.
